// File: rtl/stream_fifo_quota_arbiter.sv
// Round-robin write-port arbiter for a shared stream FIFO with a per-source
// occupancy quota. Each push is tagged with its source id; the consumer hands
// the id back on the release port when the entry leaves the FIFO.

// Per-requester occupancy counter: +1 on push, -1 on release, flags an
// underflowing release instead of wrapping.
module stream_fifo_quota_cnt #(
   parameter int QCNT_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   input  logic                  dec,
   output logic [QCNT_WIDTH-1:0] occ,
   output logic                  err_pulse
);
   // A release with nothing resident is an upstream bug; hold at 0 and report.
   assign err_pulse = dec && !inc && (occ == '0);

   // Push and release in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst)
         occ <= '0;
      else if (inc && !dec)
         occ <= occ + QCNT_WIDTH'(1);
      else if (dec && !inc && (occ != '0))
         occ <= occ - QCNT_WIDTH'(1);
   end
endmodule

module stream_fifo_quota_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 32,
   parameter int QUOTA      = 2,
   parameter int QCNT_WIDTH = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   output logic [NUM_REQ-1:0]               req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
   output logic                             w_valid_o,
   input  logic                             w_ready_i,
   output logic [DATA_WIDTH-1:0]            w_data_o,
   output logic [ID_WIDTH-1:0]              w_id_o,
   input  logic                             rel_valid_i,
   input  logic [ID_WIDTH-1:0]              rel_id_i,
   output logic [NUM_REQ*QCNT_WIDTH-1:0]    occ_o,
   output logic                             err_o
);
   typedef enum logic {ARB, HOLD} state_t;

   state_t                               state, state_nxt;
   logic [ID_WIDTH-1:0]                  ptr, lock_id, grant, rr_grant, idx;
   logic                                 rr_any, w_valid, fire;
   logic [NUM_REQ-1:0]                   eligible, inc, dec, err_pulse;
   logic [NUM_REQ-1:0][QCNT_WIDTH-1:0]   occ;

   // Per-lane eligibility, counters and ready/occupancy fan-out.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign eligible[i] = req_valid_i[i] && (occ[i] < QCNT_WIDTH'(QUOTA));
      assign inc[i]      = fire && (grant == ID_WIDTH'(i));
      assign dec[i]      = rel_valid_i && (rel_id_i == ID_WIDTH'(i));
      assign req_ready_o[i] = inc[i];
      assign occ_o[i*QCNT_WIDTH +: QCNT_WIDTH] = occ[i];

      stream_fifo_quota_cnt #(.QCNT_WIDTH(QCNT_WIDTH)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc[i]),
         .dec       (dec[i]),
         .occ       (occ[i]),
         .err_pulse (err_pulse[i])
      );
   end

   // Rotating priority scan starting at ptr; scanning downward lets the
   // nearest eligible index overwrite farther ones.
   always_comb begin
      rr_any   = 1'b0;
      rr_grant = ptr;
      idx      = ptr;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         idx = ptr + ID_WIDTH'(k);
         if (eligible[idx]) begin
            rr_any   = 1'b1;
            rr_grant = idx;
         end
      end
   end

   // Next state and grant: HOLD pins the offered grant so data stays stable
   // under backpressure; a dropped valid abandons it.
   always_comb begin
      state_nxt = state;
      grant     = rr_grant;
      w_valid   = rr_any;
      case (state)
         ARB: begin
            if (w_valid && !w_ready_i) state_nxt = HOLD;
         end
         HOLD: begin
            grant   = lock_id;
            w_valid = eligible[lock_id];
            if (w_valid && w_ready_i)      state_nxt = ARB;
            else if (!req_valid_i[lock_id]) state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
      if (rst) w_valid = 1'b0;
   end

   assign fire      = w_valid && w_ready_i;
   assign w_valid_o = w_valid;
   assign w_id_o    = grant;
   assign w_data_o  = req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];

   // State, rotation pointer and held grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ARB;
         ptr     <= '0;
         lock_id <= '0;
      end else begin
         state <= state_nxt;
         if (fire) ptr <= grant + ID_WIDTH'(1);
         if (state == ARB && w_valid && !w_ready_i) lock_id <= grant;
      end
   end

   // Sticky release-underflow flag.
   always_ff @(posedge clk) begin
      if (rst)             err_o <= 1'b0;
      else if (|err_pulse) err_o <= 1'b1;
   end
endmodule

// File: tb/tb_stream_fifo_quota_arbiter.sv
// Directed + randomized bench for stream_fifo_quota_arbiter with a
// behavioural reference model (occupancy table, rotating start, pending offer).
module tb_stream_fifo_quota_arbiter;
   localparam int N = 4, IW = 2, DW = 32, Q = 2, QW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid, req_ready;
   logic [N*DW-1:0]   req_data;
   logic              w_valid, w_ready;
   logic [DW-1:0]     w_data;
   logic [IW-1:0]     w_id;
   logic              rel_valid;
   logic [IW-1:0]     rel_id;
   logic [N*QW-1:0]   occ;
   logic              err;

   stream_fifo_quota_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW),
                               .QUOTA(Q), .QCNT_WIDTH(QW)) dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_data_i(req_data), .w_valid_o(w_valid), .w_ready_i(w_ready),
      .w_data_o(w_data), .w_id_o(w_id), .rel_valid_i(rel_valid),
      .rel_id_i(rel_id), .occ_o(occ), .err_o(err));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   // reference model
   int m_occ[N];
   int m_ptr, m_stuck;
   bit m_err;
   int e_grant;
   bit e_valid;
   // last sampled DUT outputs
   logic          lv_valid;
   logic [IW-1:0] lv_id;
   logic [DW-1:0] lv_data;
   logic [N-1:0]  lv_ready;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_occ[i] = 0;
      m_ptr = 0; m_stuck = -1; m_err = 0;
   endfunction

   // Offer: a pending (refused) offer persists; otherwise nearest eligible from m_ptr.
   function automatic void model_out();
      e_valid = 0; e_grant = 0;
      if (m_stuck >= 0) begin
         e_grant = m_stuck;
         e_valid = req_valid[m_stuck] && (m_occ[m_stuck] < Q);
      end else begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!e_valid && req_valid[i] && m_occ[i] < Q) begin
               e_valid = 1; e_grant = i;
            end
         end
      end
   endfunction

   // Called at a negedge after inputs are set: check, advance model, move to next negedge.
   task automatic step();
      bit fire, inc, dec;
      #1;
      lv_valid = w_valid; lv_id = w_id; lv_data = w_data; lv_ready = req_ready;
      model_out();
      chk("w_valid", w_valid, e_valid);
      chk("req_ready", req_ready, (e_valid && w_ready) ? (64'd1 << e_grant) : 64'd0);
      if (e_valid) begin
         chk("w_id", w_id, e_grant);
         chk("w_data", w_data, req_data[e_grant*DW +: DW]);
      end
      for (int i = 0; i < N; i++) chk($sformatf("occ%0d", i), occ[i*QW +: QW], m_occ[i]);
      chk("err", err, m_err);
      fire = e_valid && w_ready;
      for (int i = 0; i < N; i++) begin
         inc = fire && (e_grant == i);
         dec = rel_valid && (rel_id == i);
         if (inc && !dec) m_occ[i]++;
         else if (dec && !inc) begin
            if (m_occ[i] > 0) m_occ[i]--; else m_err = 1;
         end
      end
      if (fire) begin m_ptr = (e_grant + 1) % N; m_stuck = -1; end
      else if (m_stuck >= 0) begin if (!req_valid[m_stuck]) m_stuck = -1; end
      else if (e_valid) m_stuck = e_grant;
      @(posedge clk);
      if (fire) req_data[e_grant*DW +: DW] = $urandom;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; req_valid = '1; w_ready = 1; rel_valid = 0; rel_id = '0;
      repeat (2) begin
         #1;
         chk("rst_w_valid", w_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         @(negedge clk);
      end
      rst = 0; req_valid = '0;
      model_reset();
   endtask

   initial begin
      logic [DW-1:0] held;
      int nf;
      rst = 1; req_valid = '0; w_ready = 0; rel_valid = 0; rel_id = '0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
      model_reset();
      @(negedge clk);
      do_reset();

      // Rotation: all valid, release the previously fired id each cycle.
      req_valid = '1; w_ready = 1;
      for (int k = 0; k < 8; k++) begin
         rel_valid = (k > 0); rel_id = IW'((k + 3) % N);
         step();
         chk("rr_id", lv_id, k % N);
      end
      req_valid = '0; rel_valid = 1; rel_id = 2'd3; step();
      rel_valid = 0;

      // Quota: only requester 2, no releases.
      req_valid = 4'b0100; nf = 0;
      for (int k = 0; k < 4; k++) begin step(); nf += int'(lv_valid && w_ready); end
      chk("quota_fires", nf, 2);
      chk("quota_occ2", occ[2*QW +: QW], 2);
      rel_valid = 1; rel_id = 2'd2; step();
      chk("quota_blocked", lv_valid, 0);
      rel_valid = 0; step();
      chk("quota_refire", lv_valid, 1);
      chk("quota_refire_id", lv_id, 2);

      // Backpressure and hold.
      do_reset();
      req_valid = 4'b1010; w_ready = 0;
      step(); held = lv_data;
      chk("bp_id0", lv_id, 1);
      req_valid = 4'b1011;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("bp_id", lv_id, 1);
         chk("bp_data", lv_data, held);
      end
      w_ready = 1; step();
      chk("bp_fire_id", lv_id, 1);
      chk("bp_fire_ready", lv_ready, 4'b0010);
      step();
      chk("bp_next_id", lv_id, 3);

      // Simultaneous fire and release on requester 0.
      do_reset();
      req_valid = 4'b0001; w_ready = 1; step();
      rel_valid = 1; rel_id = 2'd0; step();
      req_valid = '0; rel_valid = 0; step();
      chk("simul_occ0", occ[0 +: QW], 1);

      // Randomized traffic.
      do_reset();
      for (int k = 0; k < 400; k++) begin
         int rid;
         req_valid = N'($urandom);
         w_ready   = ($urandom_range(0, 9) < 7);
         rid       = $urandom_range(0, N-1);
         rel_valid = ($urandom_range(0, 9) < 4) && (m_occ[rid] > 0);
         rel_id    = IW'(rid);
         step();
      end

      // Underflowing release sets the sticky error.
      do_reset();
      rel_valid = 1; rel_id = 2'd2; step();
      rel_valid = 0;
      step();
      chk("err_set", err, 1);
      req_valid = 4'b0011;
      repeat (3) step();
      chk("err_sticky", err, 1);
      do_reset();
      #1 chk("err_cleared", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
